// File: rtl/des_pkg.sv
// Shared DES definitions for the S-box scheduler slice.
//   CHUNK_W / NIBBLE_W / NUM_BOXES : S-box input width, output width, box count
//   sched_state_t                  : scheduler FSM encoding
//   SBOX_TABLE                     : FIPS 46-3 S-boxes, indexed [box][row][col]
package des_pkg;

  localparam int unsigned CHUNK_W   = 6;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned NUM_BOXES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Each 64-bit constant is one table row, column 0 in the leftmost nibble.
  localparam logic [0:NUM_BOXES-1][0:3][0:15][NIBBLE_W-1:0] SBOX_TABLE = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

endpackage

// File: rtl/des_sbox_lookup.sv
// Combinational single S-box lookup.
//   i_box    : S-box index, 0 = S1 .. 7 = S8
//   i_chunk  : 6-bit chunk in DES bit order [1:6]
//   o_result : 4-bit substitution result [1:4]
module des_sbox_lookup
  import des_pkg::*;
(
  input  logic [2:0] i_box,
  input  logic [1:6] i_chunk,
  output logic [1:4] o_result
);

  logic [1:0] w_row;
  logic [3:0] w_col;

  // Outer bits select the row, inner four bits the column.
  assign w_row    = {i_chunk[1], i_chunk[6]};
  assign w_col    = i_chunk[2:5];
  assign o_result = SBOX_TABLE[i_box][w_row][w_col];

endmodule

// File: rtl/des_sbox_sched.sv
// Time-multiplexed S-box stage of one DES f-function round.
// Takes the 48-bit post-key-mix word, runs LANES lookups per cycle over
// 8/LANES cycles, and offers the 32-bit substitution result downstream.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : synchronous abort of the word in flight
//   in_data/valid/ready   : 48-bit input handshake (DES bit 1 = MSB)
//   out_data/valid/ready  : 32-bit output handshake (S1 nibble = MSB)
//   busy                  : a word is held (RUN or DONE)
module des_sbox_sched
  import des_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [47:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int unsigned STEPS  = NUM_BOXES / LANES;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_sched: LANES must be 1, 2, 4 or 8");
  end

  sched_state_t                                r_state;
  logic [STEP_W-1:0]                           r_step;
  logic [0:NUM_BOXES-1][CHUNK_W-1:0]           r_in;
  logic [0:NUM_BOXES-1][NIBBLE_W-1:0]          r_out;

  logic [2:0]          w_box [LANES];
  logic [NIBBLE_W-1:0] w_res [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign w_box[j] = 3'(32'(r_step) * LANES + j);

    des_sbox_lookup u_lookup (
      .i_box    (w_box[j]),
      .i_chunk  (r_in[w_box[j]]),
      .o_result (w_res[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_in    <= '0;
      r_out   <= '0;
    end else if (flush) begin
      // Control state only; data registers are simply left unqualified.
      r_state <= IDLE;
      r_step  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in    <= in_data;
            r_out   <= '0;
            r_step  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned j = 0; j < LANES; j++) begin
            r_out[w_box[j]] <= w_res[j];
          end
          if (r_step == STEP_W'(STEPS - 1)) begin
            r_step  <= '0;
            r_state <= DONE;
          end else begin
            r_step  <= r_step + STEP_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out;

endmodule
